// File: rtl/mem_xbar_pkg.sv
// rtl/mem_xbar_pkg.sv - address map, defaults and master FSM states for mem_xbar
package configure;

   localparam int NUM_SLAVES_DEF     = 4;
   localparam int TIMEOUT_CYCLES_DEF = 1024;
   localparam int MAP_ADDR_W         = 32;

   // Slave k owns [slave_base[k], slave_top[k]); index 0 is the rightmost entry
   localparam logic [NUM_SLAVES_DEF-1:0][MAP_ADDR_W-1:0] slave_base = {
      32'h0030_0000, 32'h0020_0000, 32'h0010_0000, 32'h0000_0000
   };
   localparam logic [NUM_SLAVES_DEF-1:0][MAP_ADDR_W-1:0] slave_top = {
      32'h0030_0010, 32'h0020_0010, 32'h0010_0010, 32'h0001_0000
   };

   typedef enum logic [1:0] {
      IDLE,
      WAIT_GRANT,
      WAIT_READY,
      DECERR
   } mst_state_t;

endpackage

// File: rtl/mem_xbar_if.sv
// rtl/mem_xbar_if.sv - bus bundle between core masters, crossbar and slaves
interface mem_xbar_if #(
   parameter int NUM_SLAVES = 4,
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32
);
   logic                                  imemory_valid, dmemory_valid;
   logic                                  imemory_instr, dmemory_instr;
   logic [ADDR_W-1:0]                     imemory_addr, dmemory_addr;
   logic [DATA_W-1:0]                     imemory_wdata, dmemory_wdata;
   logic [DATA_W/8-1:0]                   imemory_wstrb, dmemory_wstrb;
   logic [DATA_W-1:0]                     imemory_rdata, dmemory_rdata;
   logic                                  imemory_ready, dmemory_ready;
   logic                                  imemory_err, dmemory_err;

   logic [NUM_SLAVES-1:0]                 slave_valid;
   logic [NUM_SLAVES-1:0]                 slave_instr;
   logic [NUM_SLAVES-1:0][ADDR_W-1:0]     slave_addr;
   logic [NUM_SLAVES-1:0][DATA_W-1:0]     slave_wdata;
   logic [NUM_SLAVES-1:0][DATA_W/8-1:0]   slave_wstrb;
   logic [NUM_SLAVES-1:0][DATA_W-1:0]     slave_rdata;
   logic [NUM_SLAVES-1:0]                 slave_ready;

   // Core side: issues requests, receives responses
   modport master (
      output imemory_valid, imemory_instr, imemory_addr, imemory_wdata, imemory_wstrb,
      output dmemory_valid, dmemory_instr, dmemory_addr, dmemory_wdata, dmemory_wstrb,
      input  imemory_rdata, imemory_ready, imemory_err,
      input  dmemory_rdata, dmemory_ready, dmemory_err,
      input  slave_valid, slave_instr, slave_addr, slave_wdata, slave_wstrb,
      output slave_rdata, slave_ready
   );

   // Crossbar side: serves the core masters and drives the slave ports
   modport slave (
      input  imemory_valid, imemory_instr, imemory_addr, imemory_wdata, imemory_wstrb,
      input  dmemory_valid, dmemory_instr, dmemory_addr, dmemory_wdata, dmemory_wstrb,
      output imemory_rdata, imemory_ready, imemory_err,
      output dmemory_rdata, dmemory_ready, dmemory_err,
      output slave_valid, slave_instr, slave_addr, slave_wdata, slave_wstrb,
      input  slave_rdata, slave_ready
   );
endinterface

// File: rtl/mem_xbar_arb.sv
// rtl/mem_xbar_arb.sv - per-slave two-requester round-robin arbiter with busy/owner tracking
module mem_xbar_arb (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,     // bit 0 = instruction master, bit 1 = data master
   input  logic       ready,
   input  logic       abort,
   output logic [1:0] gnt,
   output logic       active,
   output logic       owner
);
   logic busy;
   logic ptr;   // 1 = data master has priority on the next contended grant
   logic rel;   // a response was taken last cycle; slave frees at the end of this one

   // Grant only a free slave; the pointer breaks ties
   always_comb begin
      gnt = 2'b00;
      if (!busy) begin
         if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
         else              gnt = req;
      end
   end

   // Responses are accepted only once per transaction and never while idle
   assign active = busy & ~rel;

   // Ownership, release and round-robin pointer state
   always_ff @(posedge clk) begin
      if (rst) begin
         busy  <= 1'b0;
         owner <= 1'b0;
         ptr   <= 1'b1;
         rel   <= 1'b0;
      end else begin
         rel <= active & ready & ~abort;
         if (gnt != 2'b00) begin
            busy  <= 1'b1;
            owner <= gnt[1];
            if (req == 2'b11) ptr <= ~ptr;
         end else if (rel || abort) begin
            busy <= 1'b0;
         end
      end
   end
endmodule

// File: rtl/mem_xbar.sv
// rtl/mem_xbar.sv - two-master N-slave memory crossbar; optional MEM_XBAR_TIMEOUT_EN response timeout
module mem_xbar
   import configure::*;
#(
   parameter int NUM_SLAVES     = NUM_SLAVES_DEF,
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input logic       clk,
   input logic       rst,
   mem_xbar_if.slave bus
);
   localparam int STRB_W = DATA_W / 8;
   localparam int IDX_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

   // Master index 0 = instruction port, 1 = data port
   logic [1:0]        m_valid, m_instr;
   logic [ADDR_W-1:0] m_addr  [2];
   logic [DATA_W-1:0] m_wdata [2];
   logic [STRB_W-1:0] m_wstrb [2];

   mst_state_t        state    [2];
   mst_state_t        state_nx [2];
   logic [ADDR_W-1:0] addr_q   [2];
   logic [DATA_W-1:0] wdata_q  [2];
   logic [STRB_W-1:0] wstrb_q  [2];
   logic [1:0]        instr_q;
   logic [IDX_W-1:0]  tgt_q    [2];

   logic [1:0]        hit;
   logic [IDX_W-1:0]  idx [2];
   logic [1:0]        req [NUM_SLAVES];
   logic [1:0]        gnt [NUM_SLAVES];
   logic [NUM_SLAVES-1:0] active, owner, abort;
   logic [1:0]        granted, resp, tmo;
   logic [1:0]        rdy_o, err_o;
   logic [DATA_W-1:0] rdata_o [2];

   assign m_valid    = {bus.dmemory_valid, bus.imemory_valid};
   assign m_instr    = {bus.dmemory_instr, bus.imemory_instr};
   assign m_addr[0]  = bus.imemory_addr;
   assign m_addr[1]  = bus.dmemory_addr;
   assign m_wdata[0] = bus.imemory_wdata;
   assign m_wdata[1] = bus.dmemory_wdata;
   assign m_wstrb[0] = bus.imemory_wstrb;
   assign m_wstrb[1] = bus.dmemory_wstrb;

   // Address decode; scanning downwards lets the lowest matching slave win
   always_comb begin
      for (int m = 0; m < 2; m++) begin
         hit[m] = 1'b0;
         idx[m] = '0;
         for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
            if (m_addr[m] >= ADDR_W'(slave_base[k]) && m_addr[m] < ADDR_W'(slave_top[k])) begin
               hit[m] = 1'b1;
               idx[m] = IDX_W'(k);
            end
         end
      end
   end

   // Per-slave request vectors from masters waiting for a grant
   always_comb begin
      for (int k = 0; k < NUM_SLAVES; k++) begin
         req[k] = 2'b00;
         for (int m = 0; m < 2; m++)
            req[k][m] = (state[m] == WAIT_GRANT) && (tgt_q[m] == IDX_W'(k));
      end
   end

   for (genvar k = 0; k < NUM_SLAVES; k++) begin : g_arb
      mem_xbar_arb u_arb (
         .clk    (clk),
         .rst    (rst),
         .req    (req[k]),
         .ready  (bus.slave_ready[k]),
         .abort  (abort[k]),
         .gnt    (gnt[k]),
         .active (active[k]),
         .owner  (owner[k])
      );
   end

   // Fold grants per master and detect responses owned by each master
   always_comb begin
      granted = 2'b00;
      for (int k = 0; k < NUM_SLAVES; k++) granted = granted | gnt[k];
      for (int m = 0; m < 2; m++)
         resp[m] = (state[m] == WAIT_READY) && active[tgt_q[m]] &&
                   (owner[tgt_q[m]] == 1'(m)) && bus.slave_ready[tgt_q[m]];
   end

`ifdef MEM_XBAR_TIMEOUT_EN
   logic [31:0] cnt [2];

   // Count cycles spent waiting for the owned slave
   always_ff @(posedge clk) begin
      for (int m = 0; m < 2; m++) begin
         if (rst || state[m] != WAIT_READY) cnt[m] <= '0;
         else                               cnt[m] <= cnt[m] + 32'd1;
      end
   end

   // Give up on a slave that has not answered within the budget
   always_comb begin
      for (int m = 0; m < 2; m++)
         tmo[m] = (state[m] == WAIT_READY) && (cnt[m] == 32'(TIMEOUT_CYCLES)) && !resp[m];
   end
`else
   logic unused_timeout;
   assign unused_timeout = |TIMEOUT_CYCLES;
   assign tmo = 2'b00;
`endif

   // A timed-out master releases its slave
   always_comb begin
      abort = '0;
      for (int m = 0; m < 2; m++)
         if (tmo[m]) abort[tgt_q[m]] = 1'b1;
   end

   // Master FSM next-state logic; requests outside IDLE are ignored
   always_comb begin
      for (int m = 0; m < 2; m++) begin
         state_nx[m] = state[m];
         case (state[m])
            IDLE:       if (m_valid[m]) state_nx[m] = hit[m] ? WAIT_GRANT : DECERR;
            WAIT_GRANT: if (granted[m]) state_nx[m] = WAIT_READY;
            WAIT_READY: if (resp[m] || tmo[m]) state_nx[m] = IDLE;
            DECERR:     state_nx[m] = IDLE;
            default:    state_nx[m] = IDLE;
         endcase
      end
   end

   // Master FSM state and request buffer registers
   always_ff @(posedge clk) begin
      for (int m = 0; m < 2; m++) begin
         if (rst) begin
            state[m]   <= IDLE;
            addr_q[m]  <= '0;
            wdata_q[m] <= '0;
            wstrb_q[m] <= '0;
            instr_q[m] <= 1'b0;
            tgt_q[m]   <= '0;
         end else begin
            state[m] <= state_nx[m];
            if (state[m] == IDLE && m_valid[m] && hit[m]) begin
               addr_q[m]  <= m_addr[m] ^ ADDR_W'(slave_base[idx[m]]);
               wdata_q[m] <= m_wdata[m];
               wstrb_q[m] <= m_wstrb[m];
               instr_q[m] <= m_instr[m];
               tgt_q[m]   <= idx[m];
            end
         end
      end
   end

   // Slave request pulses carry the granted master's buffer, zero otherwise
   always_comb begin
      bus.slave_valid = '0;
      bus.slave_instr = '0;
      bus.slave_addr  = '0;
      bus.slave_wdata = '0;
      bus.slave_wstrb = '0;
      for (int k = 0; k < NUM_SLAVES; k++) begin
         if (gnt[k] != 2'b00) begin
            bus.slave_valid[k] = 1'b1;
            bus.slave_instr[k] = gnt[k][1] ? instr_q[1] : instr_q[0];
            bus.slave_addr[k]  = gnt[k][1] ? addr_q[1]  : addr_q[0];
            bus.slave_wdata[k] = gnt[k][1] ? wdata_q[1] : wdata_q[0];
            bus.slave_wstrb[k] = gnt[k][1] ? wstrb_q[1] : wstrb_q[0];
         end
      end
   end

   // Master responses: routed slave data, decode error or timeout error
   always_comb begin
      for (int m = 0; m < 2; m++) begin
         rdy_o[m]   = 1'b0;
         err_o[m]   = 1'b0;
         rdata_o[m] = '0;
         if (state[m] == DECERR || tmo[m]) begin
            rdy_o[m] = 1'b1;
            err_o[m] = 1'b1;
         end else if (resp[m]) begin
            rdy_o[m]   = 1'b1;
            rdata_o[m] = bus.slave_rdata[tgt_q[m]];
         end
      end
   end

   assign bus.imemory_ready = rdy_o[0];
   assign bus.imemory_err   = err_o[0];
   assign bus.imemory_rdata = rdata_o[0];
   assign bus.dmemory_ready = rdy_o[1];
   assign bus.dmemory_err   = err_o[1];
   assign bus.dmemory_rdata = rdata_o[1];
endmodule
